// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch flushes, multiply freezes.
// Optional stall statistics counter enabled by defining PIPELINE_STALL_STATS_EN.
module pipeline_controller #(
   parameter int REG_ADDR_W = 3,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  ex_memRead,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  mul_start,
   input  logic                  mem_busy,
   output logic                  pc_we,
   output logic                  ifid_we,
   output logic                  idex_we,
   output logic                  exmem_we,
   output logic                  memwb_we,
   output logic                  idex_bubble,
   output logic                  ifid_flush_n,
   output logic                  idex_flush_n,
   output logic                  mul_done,
   output logic [15:0]           stall_cycles,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MUL_BUSY = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             flush_n_q, flush_n_next;
   logic             load_use;

   // Valid/ready style is not used here: every enable is a pure function of state and this cycle's inputs.
   assign load_use = ex_memRead && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

   always_ff @(posedge clk or negedge flush) begin
      if (!flush) begin
         state     <= RUN;
         cnt       <= '0;
         flush_n_q <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         flush_n_q <= flush_n_next;
      end
   end

   always_comb begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_we     = 1'b0;
      idex_bubble  = 1'b0;
      mul_done     = 1'b0;
      state_next   = state;
      cnt_next     = cnt;
      flush_n_next = flush_n_q;
      // While in reset or waiting on memory everything holds and all enables stay low.
      if (flush && !mem_busy) begin
         flush_n_next = 1'b1;
         case (state)
            RUN: begin
               if (branch_taken) begin
                  {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                  state_next   = FLUSH;
                  flush_n_next = 1'b0;
               end else if (mul_start) begin
                  cnt_next   = CNT_W'(MUL_CYCLES - 2);
                  state_next = MUL_BUSY;
               end else if (load_use) begin
                  {idex_we, exmem_we, memwb_we} = 3'b111;
                  idex_bubble = 1'b1;
               end else begin
                  {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
               end
            end
            FLUSH: begin
               exmem_we   = 1'b1;
               memwb_we   = 1'b1;
               state_next = RUN;
            end
            MUL_BUSY: begin
               if (cnt == '0) begin
                  {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                  mul_done   = 1'b1;
                  state_next = RUN;
               end else begin
                  cnt_next = cnt - CNT_W'(1);
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign ifid_flush_n = flush_n_q;
   assign idex_flush_n = flush_n_q;
   assign fsm_state    = state;

`ifdef PIPELINE_STALL_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge flush) begin
      if (!flush) begin
         stall_q <= '0;
      end else if (!pc_we && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller (stall counter checked when PIPELINE_STALL_STATS_EN is defined).
module tb_pipeline_controller;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_FLUSH = 2'd1;
   localparam logic [1:0] S_MUL   = 2'd2;

   logic        clk;
   logic        flush;
   logic [2:0]  id_rs, id_rt, ex_rd;
   logic        ex_memRead, branch_taken, mul_start, mem_busy;
   logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic        idex_bubble, ifid_flush_n, idex_flush_n, mul_done;
   logic [15:0] stall_cycles;
   logic [1:0]  fsm_state;
   logic [4:0]  we_vec;

   int          checks = 0;
   int          errors = 0;
   int          exp_stall = 0;
   logic [7:0]  exp_q[$];

   pipeline_controller #(.REG_ADDR_W(3), .MUL_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
      .ex_memRead(ex_memRead), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mul_start(mul_start), .mem_busy(mem_busy),
      .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
      .memwb_we(memwb_we), .idex_bubble(idex_bubble), .ifid_flush_n(ifid_flush_n),
      .idex_flush_n(idex_flush_n), .mul_done(mul_done), .stall_cycles(stall_cycles),
      .fsm_state(fsm_state)
   );

   assign we_vec = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] stall_exp();
`ifdef PIPELINE_STALL_STATS_EN
      return 16'(exp_stall);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic mr,
                        input logic [2:0] rd, input logic bt, input logic ms, input logic mb);
      id_rs = rs; id_rt = rt; ex_memRead = mr; ex_rd = rd;
      branch_taken = bt; mul_start = ms; mem_busy = mb;
   endtask

   task automatic idle();
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Sample one cycle at the falling edge, then advance past the next rising edge.
   task automatic cycle(input string tag, input logic [4:0] ewe, input logic ebub,
                        input logic efn, input logic [1:0] est, input logic emd);
      @(negedge clk);
      check({tag, ".we"},      16'(we_vec),       16'(ewe));
      check({tag, ".bubble"},  16'(idex_bubble),  16'(ebub));
      check({tag, ".ifid_fn"}, 16'(ifid_flush_n), 16'(efn));
      check({tag, ".idex_fn"}, 16'(idex_flush_n), 16'(efn));
      check({tag, ".state"},   16'(fsm_state),    16'(est));
      check({tag, ".mul_done"},16'(mul_done),     16'(emd));
      @(posedge clk);
      if (flush && !ewe[4] && exp_stall < 65535) exp_stall++;
      #1;
   endtask

   initial begin
      flush = 1'b0;
      idle();
      @(posedge clk); #1;
      cycle("reset", 5'b00000, 1'b0, 1'b0, S_RUN, 1'b0);
      check("reset.stall", stall_cycles, 16'h0000);

      flush = 1'b1;
      cycle("release", 5'b11111, 1'b0, 1'b0, S_RUN, 1'b0);
      cycle("run", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);

      // load-use on rs, then follow-up cycle clean
      drive(3'd3, 3'd5, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      cycle("lu_rs", 5'b00111, 1'b1, 1'b1, S_RUN, 1'b0);
      idle();
      cycle("lu_next", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      drive(3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      cycle("lu_r0", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      drive(3'd1, 3'd4, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
      cycle("lu_rt", 5'b00111, 1'b1, 1'b1, S_RUN, 1'b0);
      drive(3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
      cycle("no_load", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      check("stall.lu", stall_cycles, stall_exp());

      // branch; requests during FLUSH are ignored
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      cycle("br_t", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      drive(3'd3, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
      cycle("br_t1", 5'b00011, 1'b0, 1'b0, S_FLUSH, 1'b0);
      idle();
      cycle("br_t2", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);

      // branch beats load-use and mul_start
      drive(3'd3, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
      cycle("prio_t", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      idle();
      cycle("prio_t1", 5'b00011, 1'b0, 1'b0, S_FLUSH, 1'b0);
      cycle("prio_t2", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      check("stall.br", stall_cycles, stall_exp());

      // multiply, expected sequence queued as {we, state, mul_done}
      exp_q.push_back({5'b00000, S_RUN, 1'b0});
      exp_q.push_back({5'b00000, S_MUL, 1'b0});
      exp_q.push_back({5'b00000, S_MUL, 1'b0});
      exp_q.push_back({5'b11111, S_MUL, 1'b1});
      exp_q.push_back({5'b11111, S_RUN, 1'b0});
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         cycle("mul", e[7:3], 1'b0, 1'b1, e[2:1], e[0]);
         idle();
      end
      check("stall.mul", stall_cycles, stall_exp());

      // mem_busy while MUL_BUSY with cnt=1, with other requests present
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      cycle("mb_start", 5'b00000, 1'b0, 1'b1, S_RUN, 1'b0);
      idle();
      cycle("mb_cnt2", 5'b00000, 1'b0, 1'b1, S_MUL, 1'b0);
      drive(3'd3, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle("mb_busy", 5'b00000, 1'b0, 1'b1, S_MUL, 1'b0);
      idle();
      cycle("mb_cnt1", 5'b00000, 1'b0, 1'b1, S_MUL, 1'b0);
      cycle("mb_done", 5'b11111, 1'b0, 1'b1, S_MUL, 1'b1);
      cycle("mb_after", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);

      // pending branch held across mem_busy in RUN, then mem_busy during FLUSH
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
      cycle("pb_busy", 5'b00000, 1'b0, 1'b1, S_RUN, 1'b0);
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      cycle("pb_take", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      cycle("fl_busy", 5'b00000, 1'b0, 1'b0, S_FLUSH, 1'b0);
      idle();
      cycle("fl_go", 5'b00011, 1'b0, 1'b0, S_FLUSH, 1'b0);
      cycle("fl_end", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      check("stall.busy", stall_cycles, stall_exp());

      // asynchronous reset in the middle of a multiply
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      cycle("rm_start", 5'b00000, 1'b0, 1'b1, S_RUN, 1'b0);
      idle();
      #2 flush = 1'b0;
      exp_stall = 0;
      #1;
      check("rm.we", 16'(we_vec), 16'h0000);
      check("rm.state", 16'(fsm_state), 16'(S_RUN));
      check("rm.fn", 16'(ifid_flush_n), 16'h0000);
      check("rm.stall", stall_cycles, 16'h0000);
      @(posedge clk); #1;
      cycle("rm_hold", 5'b00000, 1'b0, 1'b0, S_RUN, 1'b0);
      flush = 1'b1;
      cycle("rm_rel", 5'b11111, 1'b0, 1'b0, S_RUN, 1'b0);
      for (int i = 0; i < 3; i++) cycle("rm_idle", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
      check("rm.stall0", stall_cycles, stall_exp());

      // one clean multiply after reset: three stalled cycles
      drive(3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      cycle("m3_start", 5'b00000, 1'b0, 1'b1, S_RUN, 1'b0);
      idle();
      cycle("m3_b2", 5'b00000, 1'b0, 1'b1, S_MUL, 1'b0);
      cycle("m3_b1", 5'b00000, 1'b0, 1'b1, S_MUL, 1'b0);
      cycle("m3_done", 5'b11111, 1'b0, 1'b1, S_MUL, 1'b1);
      cycle("m3_after", 5'b11111, 1'b0, 1'b1, S_RUN, 1'b0);
`ifdef PIPELINE_STALL_STATS_EN
      check("stall.m3", stall_cycles, 16'd3);
`else
      check("stall.m3", stall_cycles, 16'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
